// File: rtl/key_conditioner.sv
// key_conditioner
// Conditions two raw active-low pushbuttons into clean one-cycle strobes for
// the character-write stage.
//   - Each key passes through a two-flop synchronizer and an independent
//     debounce counter.
//   - key1 produces one strobe per debounced press.
//   - key0 produces one strobe per press, then auto-repeats while it is held:
//     the first repeat comes REPEAT_DELAY cycles after the press strobe, and
//     later repeats come every REPEAT_PERIOD cycles.
//
// Ports:
//   clock      in   system clock; all logic runs on the rising edge
//   reset      in   synchronous, active-high reset
//   key0_n     in   raw pushbutton, active-low (cycle-character key)
//   key1_n     in   raw pushbutton, active-low (select-character key)
//   key0       out  one-cycle press/repeat strobe
//   key1       out  one-cycle press strobe
//   key0_held  out  debounced pressed level of key0 (1 = pressed)
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic key0_n,
  input  logic key1_n,
  output logic key0,
  output logic key1,
  output logic key0_held
);

  // The debounce counter starts counting on the first edge that sees the
  // synchronized level differ from the debounced level (edge 2). The level
  // toggles when the count has reached DEBOUNCE_CYCLES, which lands on edge
  // DEBOUNCE_CYCLES+2. The repeat counters compare against parameter-1, so
  // the spacing between strobes is exact.
  localparam logic [31:0] DEB_LIMIT   = 32'(DEBOUNCE_CYCLES);
  localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Bit 0 = key0, bit 1 = key1. Raw and debounced levels are active-low.
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  deb_q, deb_d;
  logic [31:0] cnt_q [2];
  logic [31:0] cnt_d [2];

  state_t      state_q, state_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic        pulse0_s;
  logic        pressed0_s, pressed1_s;

  logic        key0_q, key0_d;
  logic        key1_q, key1_d;
  logic        held0_q, held0_d;
  logic        held1_q;

  // Debounce next-state: clear when stable, count while different, toggle at limit.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = 32'd0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LIMIT) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = 32'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 32'd1;
        end
      end else begin
        cnt_d[i] = 32'd0;
      end
    end
  end

  assign pressed0_s = ~deb_q[0];
  assign pressed1_s = ~deb_q[1];

  // key0 auto-repeat FSM. A release is tested before any count expiry, so a
  // release that coincides with an expiry issues no strobe.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    pulse0_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed0_s) begin
          state_d  = DELAY;
          rcnt_d   = 32'd0;
          pulse0_s = 1'b1;
        end else begin
          rcnt_d = 32'd0;
        end
      end
      DELAY: begin
        if (!pressed0_s) begin
          state_d = IDLE;
          rcnt_d  = 32'd0;
        end else if (rcnt_q == DELAY_LAST) begin
          state_d  = REPEAT;
          rcnt_d   = 32'd0;
          pulse0_s = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      REPEAT: begin
        if (!pressed0_s) begin
          state_d = IDLE;
          rcnt_d  = 32'd0;
        end else if (rcnt_q == PERIOD_LAST) begin
          rcnt_d   = 32'd0;
          pulse0_s = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = 32'd0;
      end
    endcase
  end

  // Output next-state. key1 wins a same-cycle collision. The FSM above is
  // unaffected, so the key0 schedule stays unchanged.
  always_comb begin
    key1_d  = pressed1_s & ~held1_q;
    key0_d  = pulse0_s & ~key1_d;
    held0_d = pressed0_s;
  end

  // All state: synchronizers, debounce, FSM and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      cnt_q   <= '{32'd0, 32'd0};
      state_q <= IDLE;
      rcnt_q  <= 32'd0;
      key0_q  <= 1'b0;
      key1_q  <= 1'b0;
      held0_q <= 1'b0;
      held1_q <= 1'b0;
    end else begin
      sync1_q <= {key1_n, key0_n};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      key0_q  <= key0_d;
      key1_q  <= key1_d;
      held0_q <= held0_d;
      held1_q <= pressed1_s;
    end
  end

  assign key0      = key0_q;
  assign key1      = key1_q;
  assign key0_held = held0_q;

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles before a key level is accepted (20 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 25000000: key0 held cycles from first pulse to first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent key0 auto-repeat pulses.
REQ-004 clock  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 key0_n  in  1  raw asynchronous pushbutton, active-low (cycle-character key).
REQ-007 key1_n  in  1  raw asynchronous pushbutton, active-low (select-character key).
REQ-008 key0  out  1  one-cycle press/repeat strobe to the character-write stage.
REQ-009 key1  out  1  one-cycle press strobe to the character-write stage.
REQ-010 key0_held  out  1  debounced pressed level of key0.

Function
REQ-011 Each raw key SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each key SHALL have an independent debounce counter of at least 32 bits.
- Counter clears whenever the synchronized level equals the debounced level.
- Otherwise it increments.
- On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
REQ-013 Edge 0 is the first rising edge sampling a new raw level. The debounced level SHALL change at edge DEBOUNCE_CYCLES+2, provided the raw level stays stable throughout.
REQ-014 A raw glitch shorter than DEBOUNCE_CYCLES SHALL produce no output activity.
REQ-015 key1 SHALL pulse high for exactly one cycle, on the cycle after the debounced press edge. Release produces no pulse.
REQ-016 key0 auto-repeat FSM SHALL have states IDLE, DELAY and REPEAT.
- IDLE -> DELAY on debounced press: one key0 pulse issued, repeat counter cleared.
- DELAY -> REPEAT after REPEAT_DELAY cycles: one key0 pulse issued, counter cleared.
- In REPEAT: one key0 pulse every REPEAT_PERIOD cycles.
- DELAY or REPEAT -> IDLE on debounced release, same cycle, with no pulse.
REQ-017 If a release and a repeat-count expiry coincide, release SHALL win and no pulse SHALL be issued.
REQ-018 If key0 and key1 strobes would assert in the same cycle, key1 SHALL assert, key0 SHALL be suppressed for that cycle, and the key0 FSM and counters SHALL advance unchanged.
REQ-019 key0_held SHALL equal the key0 debounced level (1 = pressed).
REQ-020 key0 and key1 SHALL never be high for two consecutive cycles for any parameter values of 2 or more.
REQ-021 All outputs SHALL be registered; there SHALL be no combinational path from input to output.
REQ-022 Parameters SHALL be at least 1. Counter compare SHALL use equality against (parameter-1) so that the period is exact.

Reset
REQ-023 When reset is high at a clock edge:
- synchronizer flops and debounced levels set to released (1, i.e. not pressed);
- all counters cleared;
- FSM set to IDLE;
- key0, key1 and key0_held set to 0.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse in the reset cycle or the following cycle.
REQ-025 A key held low through reset deassertion SHALL be treated as a new press. Its pulse SHALL follow REQ-013 timing, counted from the first post-reset edge.

Verification
REQ-026 Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20 and REPEAT_PERIOD=8 for all bench scenarios below.
REQ-027 key1_n low at edge 0, held 40 cycles, then released -> key1 single pulse in cycle 7; no pulse on release.
REQ-028 key0_n low 3 cycles, then high -> key0 and key0_held stay 0 throughout.
REQ-029 key0_n held low 60 cycles -> key0 pulses at cycles 7, 27, 35, 43, 51, 59 (plus any further pulse due before the debounced release); key0_held high from cycle 7.
REQ-030 key0_n and key1_n both driven low at edge 0 -> key1 pulse in cycle 7, key0 suppressed in that cycle, key0 repeat pulse at cycle 27.
REQ-031 key0_n held low; reset pulsed high for 1 cycle at cycle 30 -> outputs 0 during reset, then a fresh press pulse 7 cycles after reset deasserts.
REQ-032 key0_n released at the same edge as a repeat expiry (debounced release coincides with the count) -> no pulse; FSM returns to IDLE.
